axis_flit_serializer_tx: RTL and testbench

- Single-clock, parametrised successor to the NoC injection shim.
- Accepts AXI-Stream words from a user core, buffers them in a word FIFO, and slices each word into SERIALIZATION_FACTOR flits.
- Drives flits onto a credit-flow-controlled router input port and tracks downstream buffer credits.
- Adds features the previous shim lacked: runtime credit accounting status, credit-overflow detection, and flush-free back-to-back packet streaming.

---
 rtl/axis_flit_serializer_tx.sv | 200 ++++++++++++++++++++
 tb/tb_axis_flit_serializer_tx.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_flit_serializer_tx.sv
// AXI-Stream word to credit-flow-controlled flit serializer.
// Words are buffered in a small FIFO, sliced LSB-first into flits and issued
// only while downstream credits are available.
//
// state  | meaning
// S_IDLE | no word held; the FIFO head, if any, is loaded and may issue slice 0 at once
// S_SEND | a word is held in word_q; idx_q is the next slice to issue
module axis_flit_serializer_tx #(
  parameter int TDATA_WIDTH          = 32,
  parameter int TID_WIDTH            = 2,
  parameter int TDEST_WIDTH          = 4,
  parameter int SERIALIZATION_FACTOR = 4,
  parameter int BUFFER_DEPTH         = 8,
  parameter int FLIT_BUFFER_DEPTH    = 4,
  localparam int FLIT_WIDTH = TDATA_WIDTH / SERIALIZATION_FACTOR,
  localparam int DEST_WIDTH = TID_WIDTH + TDEST_WIDTH,
  localparam int CREDIT_W   = $clog2(FLIT_BUFFER_DEPTH + 1),
  localparam int COUNT_W    = $clog2(BUFFER_DEPTH + 1)
) (
  input  logic                   clk_noc,
  input  logic                   rst_n,
  input  logic                   axis_in_tvalid,
  output logic                   axis_in_tready,
  input  logic [TDATA_WIDTH-1:0] axis_in_tdata,
  input  logic                   axis_in_tlast,
  input  logic [TID_WIDTH-1:0]   axis_in_tid,
  input  logic [TDEST_WIDTH-1:0] axis_in_tdest,
  output logic [FLIT_WIDTH-1:0]  data_out,
  output logic [DEST_WIDTH-1:0]  dest_out,
  output logic                   is_tail_out,
  output logic                   send_out,
  input  logic                   credit_in,
  output logic [CREDIT_W-1:0]    credit_count,
  output logic [COUNT_W-1:0]     fifo_count,
  output logic                   credit_err
);

  localparam int IDX_W   = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;
  localparam int PTR_W   = $clog2(BUFFER_DEPTH);
  localparam int ENTRY_W = 1 + DEST_WIDTH + TDATA_WIDTH;
  localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(SERIALIZATION_FACTOR - 1);
  localparam logic [CREDIT_W-1:0] MAX_CREDIT = CREDIT_W'(FLIT_BUFFER_DEPTH);
  localparam logic [COUNT_W-1:0]  FULL_COUNT = COUNT_W'(BUFFER_DEPTH);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  logic [ENTRY_W-1:0]    fifo_mem [BUFFER_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [COUNT_W-1:0]    fifo_count_q, fifo_count_d;
  logic                  ready_en_q;
  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [ENTRY_W-1:0]    word_q, word_d;
  logic [CREDIT_W-1:0]   credit_q, credit_d;
  logic                  credit_err_q, credit_err_d;
  logic                  send_q, send_d;
  logic [FLIT_WIDTH-1:0] data_q, data_d;
  logic [DEST_WIDTH-1:0] dest_q, dest_d;
  logic                  tail_q, tail_d;

  logic                  push, pop, fifo_empty, issue, last_slice;
  logic [ENTRY_W-1:0]    head, cur_word;
  logic [IDX_W-1:0]      cur_idx;

  // ready_en_q keeps tready low until the first clock after reset release
  assign axis_in_tready = ready_en_q && (fifo_count_q != FULL_COUNT);
  assign push           = axis_in_tvalid && axis_in_tready;
  assign fifo_empty     = (fifo_count_q == '0);
  assign head           = fifo_mem[rd_ptr_q];
  // In IDLE the FIFO head is issued directly so the first flit leaves on the pop cycle
  assign cur_word   = (state_q == S_SEND) ? word_q : head;
  assign cur_idx    = (state_q == S_SEND) ? idx_q : '0;
  assign issue      = ((state_q == S_SEND) || !fifo_empty) && (credit_q != '0);
  assign last_slice = (cur_idx == LAST_IDX);

  // Next state, slice index and word holding register
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop    = 1'b1;
          word_d = head;
          idx_d  = '0;
          if (issue && last_slice) begin
            state_d = S_IDLE;
          end else if (issue) begin
            state_d = S_SEND;
            idx_d   = IDX_W'(1);
          end else begin
            state_d = S_SEND;
          end
        end
      end
      S_SEND: begin
        if (issue) begin
          if (last_slice) begin
            idx_d = '0;
            if (!fifo_empty) begin
              pop    = 1'b1;
              word_d = head;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO pointers and occupancy
  always_comb begin
    wr_ptr_d     = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d     = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    fifo_count_d = fifo_count_q;
    case ({push, pop})
      2'b10:   fifo_count_d = fifo_count_q + COUNT_W'(1);
      2'b01:   fifo_count_d = fifo_count_q - COUNT_W'(1);
      default: fifo_count_d = fifo_count_q;
    endcase
  end

  // Credit accounting with saturation and sticky overflow flag
  always_comb begin
    credit_d     = credit_q;
    credit_err_d = credit_err_q;
    if (issue && !credit_in) begin
      credit_d = credit_q - CREDIT_W'(1);
    end else if (!issue && credit_in) begin
      if (credit_q == MAX_CREDIT) credit_err_d = 1'b1;
      else                        credit_d     = credit_q + CREDIT_W'(1);
    end
  end

  // Registered flit outputs; payload holds its value between flits
  always_comb begin
    send_d = issue;
    data_d = data_q;
    dest_d = dest_q;
    tail_d = tail_q;
    if (issue) begin
      data_d = cur_word[cur_idx*FLIT_WIDTH +: FLIT_WIDTH];
      dest_d = cur_word[TDATA_WIDTH +: DEST_WIDTH];
      tail_d = last_slice && cur_word[ENTRY_W-1];
    end
  end

  // FIFO storage, written without reset since pointers define validity
  always_ff @(posedge clk_noc) begin
    if (push) fifo_mem[wr_ptr_q] <= {axis_in_tlast, axis_in_tid, axis_in_tdest, axis_in_tdata};
  end

  // State registers
  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
      ready_en_q   <= 1'b0;
      state_q      <= S_IDLE;
      idx_q        <= '0;
      word_q       <= '0;
      credit_q     <= MAX_CREDIT;
      credit_err_q <= 1'b0;
      send_q       <= 1'b0;
      data_q       <= '0;
      dest_q       <= '0;
      tail_q       <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
      ready_en_q   <= 1'b1;
      state_q      <= state_d;
      idx_q        <= idx_d;
      word_q       <= word_d;
      credit_q     <= credit_d;
      credit_err_q <= credit_err_d;
      send_q       <= send_d;
      data_q       <= data_d;
      dest_q       <= dest_d;
      tail_q       <= tail_d;
    end
  end

  assign data_out     = data_q;
  assign dest_out     = dest_q;
  assign is_tail_out  = tail_q;
  assign send_out     = send_q;
  assign credit_count = credit_q;
  assign fifo_count   = fifo_count_q;
  assign credit_err   = credit_err_q;

endmodule

// File: tb/tb_axis_flit_serializer_tx.sv
// Self-checking bench for axis_flit_serializer_tx (default parameters).
module tb_axis_flit_serializer_tx;
  localparam int TDW = 32, TIDW = 2, TDSTW = 4, SF = 4, BD = 8, FBD = 4;
  localparam int FW = TDW / SF, DW = TIDW + TDSTW;
  localparam int CW = $clog2(FBD + 1), NW = $clog2(BD + 1);

  logic clk_noc = 1'b0;
  logic rst_n = 1'b0;
  logic axis_in_tvalid = 1'b0;
  logic axis_in_tready;
  logic [TDW-1:0] axis_in_tdata = '0;
  logic axis_in_tlast = 1'b0;
  logic [TIDW-1:0] axis_in_tid = '0;
  logic [TDSTW-1:0] axis_in_tdest = '0;
  logic [FW-1:0] data_out;
  logic [DW-1:0] dest_out;
  logic is_tail_out, send_out, credit_in, credit_err;
  logic [CW-1:0] credit_count;
  logic [NW-1:0] fifo_count;
  logic man_credit = 1'b0;
  logic loop_en = 1'b0;

  // loop-back returns each flit's credit in the cycle its send_out is seen
  assign credit_in = man_credit || (loop_en && send_out);

  always #5 clk_noc = ~clk_noc;

  axis_flit_serializer_tx dut (
    .clk_noc(clk_noc), .rst_n(rst_n),
    .axis_in_tvalid(axis_in_tvalid), .axis_in_tready(axis_in_tready),
    .axis_in_tdata(axis_in_tdata), .axis_in_tlast(axis_in_tlast),
    .axis_in_tid(axis_in_tid), .axis_in_tdest(axis_in_tdest),
    .data_out(data_out), .dest_out(dest_out), .is_tail_out(is_tail_out),
    .send_out(send_out), .credit_in(credit_in), .credit_count(credit_count),
    .fifo_count(fifo_count), .credit_err(credit_err)
  );

  typedef struct { logic [FW-1:0] data; logic [DW-1:0] dest; logic tail; } flit_t;

  // Reference model: words accepted, flits issued, credits; queue of pending flits
  flit_t exp_q[$];
  int m_acc = 0, m_popped = 0, m_issued = 0, m_cred = FBD;
  bit m_err = 0, m_rdy = 0, m_send = 0;
  logic [FW-1:0] m_data = '0;
  logic [DW-1:0] m_dest = '0;
  logic m_tail = 1'b0;

  int n_tests = 0, n_fail = 0;
  int n_sends = 0, n_tails = 0, run = 0, max_run = 0, tail_at = 0;

  always @(posedge clk_noc or negedge rst_n) begin : model_blk
    int cred_n, issued_n, popped_n;
    bit iss, hs;
    flit_t f;
    logic [TDW-1:0] w;
    if (!rst_n) begin
      exp_q.delete();
      m_acc <= 0; m_popped <= 0; m_issued <= 0; m_cred <= FBD;
      m_err <= 0; m_rdy <= 0; m_send <= 0;
      m_data <= '0; m_dest <= '0; m_tail <= 1'b0;
    end else begin
      // a flit goes out whenever any accepted flit is pending and a credit exists
      iss = (exp_q.size() > 0) && (m_cred > 0);
      issued_n = m_issued + int'(iss);
      cred_n = m_cred - int'(iss) + int'(credit_in);
      if (cred_n > FBD) begin
        cred_n = FBD;
        m_err <= 1;
      end
      // at most one word lives outside the FIFO: the one currently being sliced
      popped_n = (m_acc < issued_n / SF + 1) ? m_acc : issued_n / SF + 1;
      hs = axis_in_tvalid && m_rdy && ((m_acc - m_popped) != BD);
      if (iss) begin
        f = exp_q.pop_front();
        m_data <= f.data; m_dest <= f.dest; m_tail <= f.tail;
      end
      if (hs) begin
        w = axis_in_tdata;
        for (int k = 0; k < SF; k++) begin
          f.data = w[k*FW +: FW];
          f.dest = {axis_in_tid, axis_in_tdest};
          f.tail = axis_in_tlast && (k == SF - 1);
          exp_q.push_back(f);
        end
      end
      m_acc <= m_acc + int'(hs);
      m_popped <= popped_n;
      m_issued <= issued_n;
      m_cred <= cred_n;
      m_send <= iss;
      m_rdy <= 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // advance to the next falling edge, compare against the model, update observations
  task automatic tick();
    @(negedge clk_noc);
    chk("send_out", 32'(send_out), 32'(m_send));
    chk("data_out", 32'(data_out), 32'(m_data));
    chk("dest_out", 32'(dest_out), 32'(m_dest));
    chk("is_tail_out", 32'(is_tail_out), 32'(m_tail));
    chk("credit_count", 32'(credit_count), 32'(m_cred));
    chk("credit_err", 32'(credit_err), 32'(m_err));
    chk("fifo_count", 32'(fifo_count), 32'(m_acc - m_popped));
    chk("tready", 32'(axis_in_tready), 32'(m_rdy && ((m_acc - m_popped) != BD)));
    if (send_out) begin
      n_sends++;
      run++;
      if (run > max_run) max_run = run;
      if (is_tail_out) begin
        n_tails++;
        tail_at = n_sends;
      end
    end else begin
      run = 0;
    end
  endtask

  task automatic do_reset();
    axis_in_tvalid = 1'b0; man_credit = 1'b0; loop_en = 1'b0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic push_word(input logic [TDW-1:0] d, input logic l, input logic [TIDW-1:0] id,
                           input logic [TDSTW-1:0] de, input int budget, output bit ok);
    axis_in_tdata = d; axis_in_tlast = l; axis_in_tid = id; axis_in_tdest = de;
    axis_in_tvalid = 1'b1;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (axis_in_tready) begin
        ok = 1;
        tick();
        break;
      end
      tick();
    end
    axis_in_tvalid = 1'b0;
  endtask

  initial begin
    bit ok;
    int s0, t0, acc;
    logic [7:0] exp_b [4];
    logic [TDW-1:0] wb;

    // reset values
    repeat (3) tick();
    chk("rst_tready", 32'(axis_in_tready), 0);
    chk("rst_credit", 32'(credit_count), 4);
    chk("rst_fifo", 32'(fifo_count), 0);
    chk("rst_send", 32'(send_out), 0);
    chk("rst_err", 32'(credit_err), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // single word, literal timing and payload
    exp_b[0] = 8'hAA; exp_b[1] = 8'hBB; exp_b[2] = 8'hCC; exp_b[3] = 8'hDD;
    axis_in_tdata = 32'hDDCCBBAA; axis_in_tlast = 1'b1; axis_in_tid = 2'd1; axis_in_tdest = 4'd5;
    axis_in_tvalid = 1'b1;
    chk("single_tready", 32'(axis_in_tready), 1);
    tick();
    axis_in_tvalid = 1'b0;
    chk("single_t1_send", 32'(send_out), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("single_send", 32'(send_out), 1);
      chk("single_data", 32'(data_out), 32'(exp_b[i]));
      chk("single_dest", 32'(dest_out), 32'h15);
      chk("single_tail", 32'(is_tail_out), (i == 3) ? 1 : 0);
    end
    tick();
    chk("single_after_send", 32'(send_out), 0);
    chk("single_credit", 32'(credit_count), 0);

    // credit stall over two words
    do_reset();
    s0 = n_sends;
    wb = 32'h44332211;
    push_word(32'h87654321, 1'b0, 2'd2, 4'd3, 4, ok);
    chk("stall_push1", 32'(ok), 1);
    push_word(wb, 1'b1, 2'd2, 4'd3, 4, ok);
    chk("stall_push2", 32'(ok), 1);
    repeat (12) tick();
    chk("stall_flits", 32'(n_sends - s0), 4);
    chk("stall_credit", 32'(credit_count), 0);
    man_credit = 1'b1;
    tick();
    man_credit = 1'b0;
    repeat (6) tick();
    chk("stall_resume_flits", 32'(n_sends - s0), 5);
    chk("stall_resume_data", 32'(data_out), 32'(wb[7:0]));
    chk("stall_resume_credit", 32'(credit_count), 0);

    // back-to-back 3-word packet with 1-cycle credit loop
    do_reset();
    loop_en = 1'b1;
    max_run = 0;
    s0 = n_sends; t0 = n_tails;
    for (int i = 0; i < 3; i++) begin
      push_word($urandom, (i == 2), 2'(i), 4'(i + 7), 4, ok);
      chk("b2b_push", 32'(ok), 1);
    end
    repeat (20) tick();
    chk("b2b_flits", 32'(n_sends - s0), 12);
    chk("b2b_run", 32'(max_run), 12);
    chk("b2b_tails", 32'(n_tails - t0), 1);
    chk("b2b_tail_pos", 32'(tail_at - s0), 12);
    chk("b2b_credit", 32'(credit_count), 4);

    // FIFO full with credits exhausted
    do_reset();
    push_word(32'h01020304, 1'b1, 2'd0, 4'd0, 4, ok);
    repeat (10) tick();
    chk("full_credit0", 32'(credit_count), 0);
    s0 = n_sends;
    acc = 0;
    ok = 1;
    while (ok && acc < 12) begin
      push_word(32'hA0000000 + 32'(acc), (acc % 3 == 2), 2'(acc), 4'(acc), 6, ok);
      if (ok) acc++;
    end
    chk("full_accepted", 32'(acc), 9);
    chk("full_fifo_count", 32'(fifo_count), 8);
    chk("full_tready", 32'(axis_in_tready), 0);
    loop_en = 1'b1;
    repeat (4) begin
      man_credit = 1'b1;
      tick();
    end
    man_credit = 1'b0;
    while (acc < 12) begin
      push_word(32'hA0000000 + 32'(acc), (acc % 3 == 2), 2'(acc), 4'(acc), 50, ok);
      chk("full_late_push", 32'(ok), 1);
      acc++;
    end
    repeat (150) tick();
    chk("full_drained", 32'(exp_q.size()), 0);
    chk("full_flits", 32'(n_sends - s0), 48);

    // credit overflow
    do_reset();
    man_credit = 1'b1;
    tick();
    man_credit = 1'b0;
    tick();
    chk("ovf_credit", 32'(credit_count), 4);
    chk("ovf_err", 32'(credit_err), 1);
    repeat (5) tick();
    chk("ovf_err_sticky", 32'(credit_err), 1);
    do_reset();
    chk("ovf_err_cleared", 32'(credit_err), 0);

    // reset mid-packet
    do_reset();
    s0 = n_sends;
    push_word(32'h55667788, 1'b1, 2'd3, 4'd9, 4, ok);
    for (int i = 0; i < 10 && (n_sends - s0) < 2; i++) tick();
    chk("midrst_two_flits", 32'(n_sends - s0), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_send", 32'(send_out), 0);
    chk("midrst_data", 32'(data_out), 0);
    chk("midrst_dest", 32'(dest_out), 0);
    chk("midrst_tail", 32'(is_tail_out), 0);
    chk("midrst_credit", 32'(credit_count), 4);
    chk("midrst_fifo", 32'(fifo_count), 0);
    chk("midrst_tready", 32'(axis_in_tready), 0);
    tick();
    rst_n = 1'b1;
    s0 = n_sends;
    repeat (10) tick();
    chk("midrst_no_flits", 32'(n_sends - s0), 0);
    chk("midrst_credit_after", 32'(credit_count), 4);

    // randomized traffic with loop-back credits and occasional spurious returns
    do_reset();
    loop_en = 1'b1;
    for (int c = 0; c < 400; c++) begin
      axis_in_tvalid = ($urandom_range(2) != 0);
      axis_in_tdata = $urandom;
      axis_in_tlast = ($urandom_range(2) == 0);
      axis_in_tid = 2'($urandom);
      axis_in_tdest = 4'($urandom);
      man_credit = ($urandom_range(9) == 0);
      if ($urandom_range(19) == 0) loop_en = ~loop_en;
      tick();
    end
    axis_in_tvalid = 1'b0;
    man_credit = 1'b0;
    loop_en = 1'b1;
    // credits withheld while loop_en was off are restored by a few manual pulses
    repeat (4) begin
      man_credit = 1'b1;
      tick();
    end
    man_credit = 1'b0;
    for (int c = 0; c < 400 && exp_q.size() != 0; c++) tick();
    chk("rand_drained", 32'(exp_q.size()), 0);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
